// File: rtl/fft_stage_seq_if.sv
// Handshake, twiddle-ROM and result bus of one radix-2 DIT FFT stage.
// slave = the stage itself, master = upstream source, twiddle ROM and downstream sink.
interface fft_stage_seq_if #(
  parameter int N        = 8,
  parameter int LOG2_PTS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [N-1:0]   in_a_r;
  logic signed [N-1:0]   in_a_i;
  logic signed [N-1:0]   in_b_r;
  logic signed [N-1:0]   in_b_i;
  logic [LOG2_PTS-2:0]   tw_addr;
  logic signed [N-1:0]   tw_r;
  logic signed [N-1:0]   tw_i;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [N-1:0]   out0_r;
  logic signed [N-1:0]   out0_i;
  logic signed [N-1:0]   out1_r;
  logic signed [N-1:0]   out1_i;
  logic                  out_last;

  modport slave (
    input  in_valid, in_a_r, in_a_i, in_b_r, in_b_i, tw_r, tw_i, out_ready,
    output in_ready, tw_addr, out_valid, out0_r, out0_i, out1_r, out1_i, out_last
  );

  modport master (
    output in_valid, in_a_r, in_a_i, in_b_r, in_b_i, tw_r, tw_i, out_ready,
    input  in_ready, tw_addr, out_valid, out0_r, out0_i, out1_r, out1_i, out_last
  );
endinterface

// File: rtl/fft_stage_seq.sv
// Streaming radix-2 DIT butterfly stage: S0 capture + twiddle address, S1 W*b, S2 a+-W*b.
// Define FFT_STAGE_SCALE_EN to halve every result (no growth); otherwise results wrap.
module fft_stage_seq #(
  parameter int N        = 8,
  parameter int Q        = 4,
  parameter int LOG2_PTS = 5,
  parameter int STAGE    = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fft_stage_seq_if.slave   bus
);
  localparam int KW = LOG2_PTS - 1;
  localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
  localparam logic [KW-1:0] K_ONE  = {{(KW-1){1'b0}}, 1'b1};
  localparam logic signed [2*N-1:0] RND_C = {{(2*N-1){1'b0}}, 1'b1} << (Q - 1);

  function automatic logic [KW-1:0] tw_index(input logic [KW-1:0] k);
    logic [KW-1:0] mask;
    mask = ~({KW{1'b1}} << STAGE);
    return (k & mask) << (KW - STAGE);
  endfunction

  // Full-precision product, rounded half-up back to the data scale.
  function automatic logic signed [2*N-1:0] mul_rnd(input logic signed [N-1:0] x,
                                                    input logic signed [N-1:0] y);
    logic signed [2*N-1:0] xe;
    logic signed [2*N-1:0] ye;
    logic signed [2*N-1:0] p;
    xe = {{N{x[N-1]}}, x};
    ye = {{N{y[N-1]}}, y};
    p  = xe * ye;
    return (p + RND_C) >>> Q;
  endfunction

  function automatic logic signed [N-1:0] reduce(input logic signed [N+1:0] v);
`ifdef FFT_STAGE_SCALE_EN
    return N'(v >>> 1);
`else
    return N'(v);
`endif
  endfunction

  logic [KW-1:0]         k_q, k_d;
  logic [KW-1:0]         tw_addr_q, tw_addr_d;
  logic                  s0_valid_q, s0_valid_d, s0_last_q, s0_last_d;
  logic signed [N-1:0]   s0_a_r_q, s0_a_r_d, s0_a_i_q, s0_a_i_d;
  logic signed [N-1:0]   s0_b_r_q, s0_b_r_d, s0_b_i_q, s0_b_i_d;
  logic                  s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic signed [N-1:0]   s1_a_r_q, s1_a_r_d, s1_a_i_q, s1_a_i_d;
  logic signed [N:0]     s1_wb_r_q, s1_wb_r_d, s1_wb_i_q, s1_wb_i_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic signed [N-1:0]   out0_r_q, out0_r_d, out0_i_q, out0_i_d;
  logic signed [N-1:0]   out1_r_q, out1_r_d, out1_i_q, out1_i_d;

  logic                  en_s;
  logic signed [2*N-1:0] p_rr_s, p_ii_s, p_ri_s, p_ir_s;
  logic signed [N:0]     wb_r_s, wb_i_s;
  logic signed [N+1:0]   sum_r_s, sum_i_s, dif_r_s, dif_i_s;

  // A stalled output register freezes the whole pipeline, k and the twiddle address.
  assign en_s = !(out_valid_q && !bus.out_ready);

  assign p_rr_s = mul_rnd(s0_b_r_q, bus.tw_r);
  assign p_ii_s = mul_rnd(s0_b_i_q, bus.tw_i);
  assign p_ri_s = mul_rnd(s0_b_r_q, bus.tw_i);
  assign p_ir_s = mul_rnd(s0_b_i_q, bus.tw_r);
  assign wb_r_s = (N+1)'(p_rr_s - p_ii_s);
  assign wb_i_s = (N+1)'(p_ri_s + p_ir_s);

  assign sum_r_s = {{2{s1_a_r_q[N-1]}}, s1_a_r_q} + {s1_wb_r_q[N], s1_wb_r_q};
  assign sum_i_s = {{2{s1_a_i_q[N-1]}}, s1_a_i_q} + {s1_wb_i_q[N], s1_wb_i_q};
  assign dif_r_s = {{2{s1_a_r_q[N-1]}}, s1_a_r_q} - {s1_wb_r_q[N], s1_wb_r_q};
  assign dif_i_s = {{2{s1_a_i_q[N-1]}}, s1_a_i_q} - {s1_wb_i_q[N], s1_wb_i_q};

  // Next-state for every stage; data registers only load behind a valid entry.
  always_comb begin
    k_d         = k_q;
    tw_addr_d   = tw_addr_q;
    s0_valid_d  = s0_valid_q;
    s0_last_d   = s0_last_q;
    s0_a_r_d    = s0_a_r_q;
    s0_a_i_d    = s0_a_i_q;
    s0_b_r_d    = s0_b_r_q;
    s0_b_i_d    = s0_b_i_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_a_r_d    = s1_a_r_q;
    s1_a_i_d    = s1_a_i_q;
    s1_wb_r_d   = s1_wb_r_q;
    s1_wb_i_d   = s1_wb_i_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out0_r_d    = out0_r_q;
    out0_i_d    = out0_i_q;
    out1_r_d    = out1_r_q;
    out1_i_d    = out1_i_q;
    if (en_s) begin
      s0_valid_d  = bus.in_valid;
      s1_valid_d  = s0_valid_q;
      out_valid_d = s1_valid_q;
      if (bus.in_valid) begin
        s0_a_r_d  = bus.in_a_r;
        s0_a_i_d  = bus.in_a_i;
        s0_b_r_d  = bus.in_b_r;
        s0_b_i_d  = bus.in_b_i;
        s0_last_d = (k_q == K_LAST);
        tw_addr_d = tw_index(k_q);
        k_d       = k_q + K_ONE;
      end else begin
        s0_last_d = 1'b0;
      end
      // tw_r/tw_i belong to the pair now in S0, so they are consumed only here.
      if (s0_valid_q) begin
        s1_a_r_d  = s0_a_r_q;
        s1_a_i_d  = s0_a_i_q;
        s1_wb_r_d = wb_r_s;
        s1_wb_i_d = wb_i_s;
        s1_last_d = s0_last_q;
      end else begin
        s1_last_d = 1'b0;
      end
      if (s1_valid_q) begin
        out0_r_d   = reduce(sum_r_s);
        out0_i_d   = reduce(sum_i_s);
        out1_r_d   = reduce(dif_r_s);
        out1_i_d   = reduce(dif_i_s);
        out_last_d = s1_last_q;
      end else begin
        out_last_d = 1'b0;
      end
    end else begin
      k_d = k_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q         <= {KW{1'b0}};
      tw_addr_q   <= {KW{1'b0}};
      s0_valid_q  <= 1'b0;
      s0_last_q   <= 1'b0;
      s0_a_r_q    <= {N{1'b0}};
      s0_a_i_q    <= {N{1'b0}};
      s0_b_r_q    <= {N{1'b0}};
      s0_b_i_q    <= {N{1'b0}};
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_a_r_q    <= {N{1'b0}};
      s1_a_i_q    <= {N{1'b0}};
      s1_wb_r_q   <= {(N+1){1'b0}};
      s1_wb_i_q   <= {(N+1){1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out0_r_q    <= {N{1'b0}};
      out0_i_q    <= {N{1'b0}};
      out1_r_q    <= {N{1'b0}};
      out1_i_q    <= {N{1'b0}};
    end else begin
      k_q         <= k_d;
      tw_addr_q   <= tw_addr_d;
      s0_valid_q  <= s0_valid_d;
      s0_last_q   <= s0_last_d;
      s0_a_r_q    <= s0_a_r_d;
      s0_a_i_q    <= s0_a_i_d;
      s0_b_r_q    <= s0_b_r_d;
      s0_b_i_q    <= s0_b_i_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_a_r_q    <= s1_a_r_d;
      s1_a_i_q    <= s1_a_i_d;
      s1_wb_r_q   <= s1_wb_r_d;
      s1_wb_i_q   <= s1_wb_i_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out0_r_q    <= out0_r_d;
      out0_i_q    <= out0_i_d;
      out1_r_q    <= out1_r_d;
      out1_i_q    <= out1_i_d;
    end
  end

  assign bus.in_ready  = en_s;
  assign bus.tw_addr   = tw_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out0_r    = out0_r_q;
  assign bus.out0_i    = out0_i_q;
  assign bus.out1_r    = out1_r_q;
  assign bus.out1_i    = out1_i_q;
endmodule

// File: tb/tb_fft_stage_seq.sv
// Scoreboard bench for fft_stage_seq (32-point, stage 2): directed pairs per k with
// hand-computed full-precision results, backpressure, frame wrap and mid-frame reset.
module tb_fft_stage_seq;
  localparam int N  = 8;
  localparam int Q  = 4;
  localparam int LP = 5;
  localparam int ST = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_stage_seq_if #(.N(N), .LOG2_PTS(LP)) bus ();

  fft_stage_seq #(.N(N), .Q(Q), .LOG2_PTS(LP), .STAGE(ST)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // W32^m table, 1.0 = 16; stage 2 only addresses m = 0, 4, 8, 12.
  int rom_r [16] = '{16, 16, 15, 13, 11, 9, 6, 3, 0, -3, -6, -9, -11, -13, -15, -16};
  int rom_i [16] = '{0, -3, -6, -9, -11, -13, -15, -16, -16, -16, -15, -13, -11, -9, -6, -3};
  assign bus.tw_r = 8'(rom_r[bus.tw_addr]);
  assign bus.tw_i = 8'(rom_i[bus.tw_addr]);

  // Per pair index k: inputs and exact a+W*b / a-W*b before width reduction.
  int ta_r [16] = '{16, 10, 16, 0, 127, 1, -20, 40, -128, 0, 100, -5, 7, -1, 0, 3};
  int ta_i [16] = '{0, -4, 0, 0, 0, 2, 30, -40, -128, 0, 100, 5, -9, -1, 0, 3};
  int tb_r [16] = '{16, 16, 16, 16, 16, 1, 5, 0, -128, 3, 50, 16, 5, 0, 127, 16};
  int tb_i [16] = '{0, 0, 0, 0, 0, 1, -7, 16, -128, 0, 60, 0, 3, 16, -128, 0};
  int e0_r [16] = '{32, 21, 16, -11, 143, 3, -27, 51, -256, 2, 160, -16, 12, 10, -128, -8};
  int e0_i [16] = '{0, -15, -16, -11, 0, 2, 25, -51, -256, -2, 50, -6, -6, 10, -127, -8};
  int e1_r [16] = '{0, -1, 16, 11, 111, -1, -13, 29, 0, -2, 40, 6, 2, -12, 128, 14};
  int e1_i [16] = '{0, 7, 16, 11, 0, 2, 35, -29, 0, 2, 150, 16, -12, -12, 127, 14};
  int ex_addr [4] = '{0, 4, 8, 12};

  typedef struct {
    int o0r;
    int o0i;
    int o1r;
    int o1i;
    int last;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  int k = 0;

  function automatic int red(input int v);
    int t;
    logic [7:0] b8;
`ifdef FFT_STAGE_SCALE_EN
    t = v >>> 1;
`else
    t = v;
`endif
    b8 = t[7:0];
    return int'($signed(b8));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_pair(input int kk);
    bus.in_a_r = 8'(ta_r[kk]);
    bus.in_a_i = 8'(ta_i[kk]);
    bus.in_b_r = 8'(tb_r[kk]);
    bus.in_b_i = 8'(tb_i[kk]);
  endtask

  // Output monitor: every delivered (or stalled) result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_unexpected: got out_valid=1, expected no pending result");
      end else begin
        chk("out0_r", int'(bus.out0_r), q[0].o0r);
        chk("out0_i", int'(bus.out0_i), q[0].o0i);
        chk("out1_r", int'(bus.out1_r), q[0].o1r);
        chk("out1_i", int'(bus.out1_i), q[0].o1i);
        chk("out_last", int'(bus.out_last), q[0].last);
        if (bus.out_ready) begin
          void'(q.pop_front());
        end
      end
    end
  end

  // Stream npairs consecutive pairs; out_ready is held low for stall_len cycles from stall_at.
  task automatic run(input int npairs, input int stall_at, input int stall_len);
    int sent = 0;
    int c = 0;
    bit acc;
    while (sent < npairs) begin
      bus.in_valid  = 1'b1;
      set_pair(k);
      bus.out_ready = !(c >= stall_at && c < stall_at + stall_len);
      @(negedge clk);
      if (!bus.out_ready) begin
        chk("in_ready_stall", int'(bus.in_ready), 0);
        chk("out_valid_stall", int'(bus.out_valid), 1);
      end
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        q.push_back('{red(e0_r[k]), red(e0_i[k]), red(e1_r[k]), red(e1_i[k]), (k == 15) ? 1 : 0});
        chk("tw_addr", int'(bus.tw_addr), ex_addr[k % 4]);
        k = (k + 1) % 16;
        sent++;
      end
      c++;
      if (c > 100) begin
        n_vec++;
        n_err++;
        $display("FAIL run_timeout: got %0d pairs accepted, expected %0d", sent, npairs);
        break;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    chk("drain_pending", q.size(), 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_pair(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_tw_addr", int'(bus.tw_addr), 0);
    chk("rst_out0_r", int'(bus.out0_r), 0);
    chk("rst_out0_i", int'(bus.out0_i), 0);
    chk("rst_out1_r", int'(bus.out1_r), 0);
    chk("rst_out1_i", int'(bus.out1_i), 0);
    rst = 1'b0;

    // Full frame, then next frame restarting at k=0 with a 5-cycle stall, then frame end.
    run(16, 1000, 0);
    run(8, 3, 5);
    run(8, 1000, 0);
    drain();

    // Six pairs into a new frame, then reset with results still in flight.
    run(6, 1000, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    k = 0;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_out_last", int'(bus.out_last), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    rst = 1'b0;
    run(4, 1000, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
